// File: rtl/print_mechanism_driver.sv
// Thermal print head driver: shifts a line serially, latches, burns, then steps the feed motor.
// Optional build macro PRINT_MECHANISM_DRIVER_SKIP_BLANK_EN sends all-zero lines straight to the feed step.
module print_mechanism_driver #(
  parameter int HEAD_WIDTH     = 384,
  parameter int CLK_DIV        = 4,
  parameter int LATCH_CYCLES   = 2,
  parameter int BURN_CYCLES    = 64,
  parameter int STEPS_PER_LINE = 2,
  parameter int STEP_CYCLES    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_valid,
  input  logic [HEAD_WIDTH-1:0] line,
  output logic                  line_ready,
  output logic                  line_done,
  output logic                  busy,
  output logic                  mech_clk,
  output logic                  mech_data,
  output logic                  mech_latch,
  output logic                  mech_dst,
  output logic                  motor_phase_a,
  output logic                  motor_phase_b,
  output logic                  motor_phase_na,
  output logic                  motor_phase_nb,
  output logic [2:0]            dbg_state
);

  localparam int BW = $clog2(HEAD_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(HEAD_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_BURN  = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  // Handshake: a line is taken on a rising edge where line_valid && line_ready; line is ignored otherwise.
  logic [2:0]            state_q, state_d;
  logic [HEAD_WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [15:0]           steps_q, steps_d;
  logic [3:0]            phase_q, phase_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  mclk_q, mclk_d;
  logic                  mdata_q, mdata_d;
  logic                  latch_q, latch_d;
  logic                  dst_q, dst_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    steps_d = steps_q;
    phase_d = phase_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    mclk_d  = mclk_q;
    mdata_d = mdata_q;
    latch_d = latch_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (line_valid) begin
          shreg_d = line;
          cnt_d   = '0;
          bits_d  = '0;
          steps_d = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef PRINT_MECHANISM_DRIVER_SKIP_BLANK_EN
          if (line == '0) begin
            state_d = S_STEP;
          end else begin
            state_d = S_SHIFT;
            mdata_d = line[HEAD_WIDTH-1];
          end
`else
          state_d = S_SHIFT;
          mdata_d = line[HEAD_WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!mclk_q) begin
            mclk_d = 1'b1;
          end else begin
            // End of the high half: advance to the next bit while the head clock is low again.
            mclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            bits_d  = bits_q + BIT_ONE;
            if (bits_q == LAST_BIT) begin
              mdata_d = 1'b0;
              latch_d = 1'b0;
              state_d = S_LATCH;
            end else begin
              mdata_d = shreg_d[HEAD_WIDTH-1];
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == 16'(LATCH_CYCLES - 1)) begin
          cnt_d   = '0;
          latch_d = 1'b1;
          dst_d   = 1'b1;
          state_d = S_BURN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BURN: begin
        if (cnt_q == 16'(BURN_CYCLES - 1)) begin
          cnt_d   = '0;
          steps_d = '0;
          dst_d   = 1'b0;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STEP: begin
        // Pattern order a,b,na,nb: rotating right walks 1100 -> 0110 -> 0011 -> 1001 -> 1100.
        if (cnt_q > 16'd1) begin
          cnt_d = cnt_q - 16'd1;
        end else if (steps_q == 16'(STEPS_PER_LINE)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          phase_d = {phase_q[0], phase_q[3:1]};
          steps_d = steps_q + 16'd1;
          cnt_d   = 16'(STEP_CYCLES);
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        mclk_d  = 1'b0;
        mdata_d = 1'b0;
        latch_d = 1'b1;
        dst_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      steps_q <= '0;
      phase_q <= 4'b1100;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mclk_q  <= 1'b0;
      mdata_q <= 1'b0;
      latch_q <= 1'b1;
      dst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      steps_q <= steps_d;
      phase_q <= phase_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mclk_q  <= mclk_d;
      mdata_q <= mdata_d;
      latch_q <= latch_d;
      dst_q   <= dst_d;
    end
  end

  assign line_ready     = ready_q;
  assign line_done      = done_q;
  assign busy           = busy_q;
  assign mech_clk       = mclk_q;
  assign mech_data      = mdata_q;
  assign mech_latch     = latch_q;
  assign mech_dst       = dst_q;
  assign motor_phase_a  = phase_q[3];
  assign motor_phase_b  = phase_q[2];
  assign motor_phase_na = phase_q[1];
  assign motor_phase_nb = phase_q[0];
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_print_mechanism_driver.sv
// Bench for print_mechanism_driver: per-cycle comparison against a line-level timeline model,
// plus directed literal checks on latency, shifted bits and motor phases.
module tb_print_mechanism_driver;

  localparam int HW  = 8;
  localparam int CD  = 2;
  localparam int LC  = 3;
  localparam int BC  = 5;
  localparam int SPL = 2;
  localparam int SC  = 4;
`ifdef PRINT_MECHANISM_DRIVER_SKIP_BLANK_EN
  localparam int BLANK_LAT = 9;
`else
  localparam int BLANK_LAT = 49;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_valid = 1'b0;
  logic [HW-1:0] line = '0;
  logic          line_ready, line_done, busy, mech_clk, mech_data, mech_latch, mech_dst;
  logic          motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  print_mechanism_driver #(
    .HEAD_WIDTH(HW), .CLK_DIV(CD), .LATCH_CYCLES(LC), .BURN_CYCLES(BC),
    .STEPS_PER_LINE(SPL), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .line_valid(line_valid), .line(line),
    .line_ready(line_ready), .line_done(line_done), .busy(busy),
    .mech_clk(mech_clk), .mech_data(mech_data), .mech_latch(mech_latch), .mech_dst(mech_dst),
    .motor_phase_a(motor_phase_a), .motor_phase_b(motor_phase_b),
    .motor_phase_na(motor_phase_na), .motor_phase_nb(motor_phase_nb),
    .dbg_state(dbg_state)
  );

  // Output vector: {ready, done, busy, mclk, mdata, latch, dst, a, b, na, nb}
  wire [10:0] act_vec = {line_ready, line_done, busy, mech_clk, mech_data, mech_latch, mech_dst,
                         motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb};
  wire [3:0]  act_ph  = {motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb};

  int          checks = 0;
  int          failures = 0;
  logic [10:0] exp_q[$];
  int          idx_m = 0;
  logic        cur_ready = 1'b1;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  logic [7:0]  cap = '0;
  int          edges = 0;
  logic        prev_mclk = 1'b0;

  function automatic logic [3:0] pat(input int i);
    case (i % 4)
      0: return 4'b1100;
      1: return 4'b0110;
      2: return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [10:0] mk(input logic rdy, input logic dn, input logic bsy, input logic mc,
                                     input logic md, input logic lt, input logic ds, input logic [3:0] ph);
    return {rdy, dn, bsy, mc, md, lt, ds, ph};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline of one line, one entry per clock cycle after the accepting edge.
  task automatic push_seq(input logic [HW-1:0] l);
    bit skip;
    skip = 1'b0;
`ifdef PRINT_MECHANISM_DRIVER_SKIP_BLANK_EN
    skip = (l == '0);
`endif
    if (!skip) begin
      for (int b = 0; b < HW; b++)
        for (int h = 0; h < 2; h++)
          for (int c = 0; c < CD; c++)
            exp_q.push_back(mk(0, 0, 1, h[0], l[HW-1-b], 1, 0, pat(idx_m)));
      for (int c = 0; c < LC; c++) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, pat(idx_m)));
      for (int c = 0; c < BC; c++) exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 1, pat(idx_m)));
    end
    exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, pat(idx_m)));
    for (int s = 0; s < SPL; s++) begin
      idx_m = (idx_m + 1) % 4;
      for (int c = 0; c < SC; c++) exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, pat(idx_m)));
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 0, pat(idx_m)));
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      idx_m = 0;
      cur_ready = 1'b1;
    end else if (cur_ready && line_valid) begin
      push_seq(line);
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    logic [10:0] exp_v;
    if (chk_en) begin
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      else exp_v = mk(1, 0, 0, 0, 0, 1, 0, pat(idx_m));
      cur_ready = exp_v[10];
      check("cycle_vec", {21'd0, act_vec}, {21'd0, exp_v});
    end
    if (mech_clk && !prev_mclk) begin
      cap = {cap[6:0], mech_data};
      edges++;
    end
    prev_mclk = mech_clk;
  end

  task automatic send_line(input logic [HW-1:0] l);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    line_valid = 1'b1;
    line = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: line %0h not accepted within 200 cycles", l);
    end
    line_valid = 1'b0;
    line = HW'($urandom);
    cap = '0;
    edges = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (line_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      failures++;
      $display("FAIL done_timeout: line_done not seen within 200 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a1;
    int dw;
    logic [HW-1:0] l;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_vec", {21'd0, act_vec}, {21'd0, 11'b100_0010_1100});
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back pair from reset: second accepted the cycle after line_done, phases wrap to 1100.
    send_line(8'h5A);
    a1 = acc_cyc;
    send_line(8'hC3);
    check("b2b_gap", acc_cyc - a1, 50);
    wait_done(lat);
    check("b2b_lat", lat, 49);
    check("b2b_bits", cap, 8'hC3);
    check("b2b_phase", act_ph, 4'b1100);

    // Single A5 line.
    send_line(8'hA5);
    wait_done(lat);
    check("a5_lat", lat, 49);
    check("a5_bits", cap, 8'hA5);
    check("a5_edges", edges, 8);
    check("a5_phase", act_ph, 4'b0011);
    check("a5_ready", line_ready, 1);

    // Blank line.
    send_line(8'h00);
    wait_done(lat);
    check("blank_lat", lat, BLANK_LAT);
`ifdef PRINT_MECHANISM_DRIVER_SKIP_BLANK_EN
    check("blank_edges", edges, 0);
`else
    check("blank_edges", edges, 8);
    check("blank_bits", cap, 8'h00);
`endif

    // Reset during BURN, then a normal line.
    send_line(8'h81);
    dw = 0;
    while (mech_dst !== 1'b1 && dw < 200) begin
      @(negedge clk);
      dw++;
    end
    check("burn_reached", mech_dst, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dst", mech_dst, 0);
    check("rst_phase", act_ph, 4'b1100);
    check("rst_ready", line_ready, 1);
    reset = 1'b1;
    send_line(8'hA5);
    wait_done(lat);
    check("post_rst_lat", lat, 49);
    check("post_rst_bits", cap, 8'hA5);
    check("post_rst_phase", act_ph, 4'b0011);

    // Randomized lines with random idle gaps; line input wiggles while busy.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      l = ($urandom_range(0, 3) == 0) ? 8'h00 : HW'($urandom);
      send_line(l);
      wait_done(lat);
      check("rand_lat", lat, (l == 8'h00) ? BLANK_LAT : 49);
      if (l != 8'h00) check("rand_bits", cap, l);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
